fir_out_fifo: RTL and testbench

//   Elastic output buffer directly downstream of myfir. Captures every filtered

---
 rtl/fir_out_fifo.sv | 139 +++++++++++++
 tb/tb_fir_out_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fir_out_fifo
//  Purpose  : Elastic output buffer behind the myfir filter. Every sample
//             flagged by VIN is captured into a synchronous FIFO and handed
//             to the sink with a valid/ready handshake (show-ahead DOUT).
//             A sample arriving while full with no pop is dropped and the
//             sticky OVF flag is raised.
//  Ports    : CLK    - clock, rising edge
//             RST_n  - synchronous active-low reset
//             CLR    - synchronous flush, active-high, beats push/pop
//             VIN    - input valid (myfir VOUT)
//             DIN    - input sample (myfir DOUT), two's complement
//             RDY    - sink ready
//             VOUT   - DOUT valid (~EMPTY)
//             DOUT   - head-of-FIFO sample, forced to 0 while empty
//             FULL   - COUNT == DEPTH
//             EMPTY  - COUNT == 0
//             COUNT  - occupancy 0..DEPTH
//             OVF    - sticky: a sample was dropped
//             MAXCNT - high-water mark of COUNT   (FIR_FIFO_STATS_EN only)
//             DROPS  - saturating drop counter    (FIR_FIFO_STATS_EN only)
//  Config   : define FIR_FIFO_STATS_EN to add the MAXCNT/DROPS statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_out_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                       CLK,
   input  logic                       RST_n,
   input  logic                       CLR,
   input  logic                       VIN,
   input  logic [WIDTH-1:0]           DIN,
   input  logic                       RDY,
   output logic                       VOUT,
   output logic [WIDTH-1:0]           DOUT,
   output logic                       FULL,
   output logic                       EMPTY,
   output logic [$clog2(DEPTH):0]     COUNT,
`ifdef FIR_FIFO_STATS_EN
   output logic [$clog2(DEPTH):0]     MAXCNT,
   output logic [7:0]                 DROPS,
`endif
   output logic                       OVF
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             r_ovf;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic             w_wr_en;
   logic [AW:0]      w_cnt_nxt;

   // Status comes from the occupancy counter only; pointer equality is
   // ambiguous between full and empty.
   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == '0);

   // A pop frees a slot in the same edge, so a full FIFO still accepts
   // a push when the sink is taking the head.
   assign w_pop   = ~w_empty & RDY;
   assign w_push  = VIN & (~w_full | w_pop);
   assign w_drop  = VIN & w_full & ~w_pop;
   assign w_wr_en = RST_n & ~CLR & w_push;

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_push & ~w_pop)
         w_cnt_nxt = r_count + c_CNT_ONE;
      else if (~w_push & w_pop)
         w_cnt_nxt = r_count - c_CNT_ONE;
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(posedge CLK) begin
      if (w_wr_en)
         r_mem[r_wr] <= DIN;
   end

   always_ff @(posedge CLK) begin
      if (!RST_n || CLR) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push)
            r_wr <= r_wr + c_PTR_ONE;
         if (w_pop)
            r_rd <= r_rd + c_PTR_ONE;
         r_count <= w_cnt_nxt;
         if (w_drop)
            r_ovf <= 1'b1;
      end
   end

`ifdef FIR_FIFO_STATS_EN
   logic [AW:0] r_maxcnt;
   logic [7:0]  r_drops;

   always_ff @(posedge CLK) begin
      if (!RST_n || CLR) begin
         r_maxcnt <= '0;
         r_drops  <= '0;
      end else begin
         if (w_cnt_nxt > r_maxcnt)
            r_maxcnt <= w_cnt_nxt;
         if (w_drop && (r_drops != 8'hFF))
            r_drops <= r_drops + 8'd1;
      end
   end

   assign MAXCNT = r_maxcnt;
   assign DROPS  = r_drops;
`endif

   assign VOUT  = ~w_empty;
   assign DOUT  = w_empty ? '0 : r_mem[r_rd];
   assign FULL  = w_full;
   assign EMPTY = w_empty;
   assign COUNT = r_count;
   assign OVF   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_out_fifo
//  Purpose  : Self-checking bench for fir_out_fifo. Directed scenarios plus
//             randomized traffic compared every cycle against a queue-based
//             reference model of the FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_fifo;

   localparam int WIDTH = 9;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic             CLK;
   logic             RST_n;
   logic             CLR;
   logic             VIN;
   logic [WIDTH-1:0] DIN;
   logic             RDY;
   logic             VOUT;
   logic [WIDTH-1:0] DOUT;
   logic             FULL;
   logic             EMPTY;
   logic [AW:0]      COUNT;
   logic             OVF;
`ifdef FIR_FIFO_STATS_EN
   logic [AW:0]      MAXCNT;
   logic [7:0]       DROPS;
`endif

   fir_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .CLK    (CLK),
      .RST_n  (RST_n),
      .CLR    (CLR),
      .VIN    (VIN),
      .DIN    (DIN),
      .RDY    (RDY),
      .VOUT   (VOUT),
      .DOUT   (DOUT),
      .FULL   (FULL),
      .EMPTY  (EMPTY),
      .COUNT  (COUNT),
`ifdef FIR_FIFO_STATS_EN
      .MAXCNT (MAXCNT),
      .DROPS  (DROPS),
`endif
      .OVF    (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue contents plus sticky flags.
   logic [WIDTH-1:0] m_q [$];
   bit               m_ovf    = 1'b0;
   int               m_maxcnt = 0;
   int               m_drops  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int n;
      n = m_q.size();
      chk("vout",  32'(VOUT),  32'(n != 0));
      chk("dout",  32'(DOUT),  (n != 0) ? 32'(m_q[0]) : 32'd0);
      chk("count", 32'(COUNT), 32'(n));
      chk("full",  32'(FULL),  32'(n == DEPTH));
      chk("empty", 32'(EMPTY), 32'(n == 0));
      chk("ovf",   32'(OVF),   32'(m_ovf));
`ifdef FIR_FIFO_STATS_EN
      chk("maxcnt", 32'(MAXCNT), 32'(m_maxcnt));
      chk("drops",  32'(DROPS),  32'(m_drops));
`endif
   endtask

   // Checks current outputs, advances the model by one edge using the
   // inputs currently applied, then crosses the edge.
   task automatic cycle();
      bit pop;
      bit push;
      int n;
      check_outputs();
      n = m_q.size();
      if (!RST_n || CLR) begin
         m_q.delete();
         m_ovf    = 1'b0;
         m_maxcnt = 0;
         m_drops  = 0;
      end else begin
         pop  = (n > 0) && RDY;
         push = VIN && ((n < DEPTH) || pop);
         if (VIN && !push) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
         if (pop)  void'(m_q.pop_front());
         if (push) m_q.push_back(DIN);
         if (m_q.size() > m_maxcnt) m_maxcnt = m_q.size();
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit rst_n, input bit clr, input bit vin,
                        input logic [WIDTH-1:0] din, input bit rdy);
      RST_n = rst_n;
      CLR   = clr;
      VIN   = vin;
      DIN   = din;
      RDY   = rdy;
   endtask

   task automatic fill(input int n, input logic [WIDTH-1:0] base);
      for (int i = 0; i < n; i++) begin
         drive(1, 0, 1, base + WIDTH'(i), 0);
         cycle();
      end
   endtask

   initial begin
      drive(0, 0, 1, 9'h0AA, 0);
      @(posedge CLK);
      #1;

      // 1: reset held 3 cycles with traffic at the input
      for (int i = 0; i < 3; i++) cycle();
      chk("rst_vout",  32'(VOUT),  32'd0);
      chk("rst_dout",  32'(DOUT),  32'd0);
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_empty", 32'(EMPTY), 32'd1);
      chk("rst_ovf",   32'(OVF),   32'd0);

      // 2: pass-through with a ready sink
      for (int i = 1; i <= 3; i++) begin
         drive(1, 0, 1, WIDTH'(i), 1);
         cycle();
         chk("pt_dout", 32'(DOUT), 32'(i));
         chk("pt_cnt",  32'(COUNT), 32'd1);
      end
      drive(1, 0, 0, '0, 1);
      cycle();

      // 3: fill, overflow, drain in order
      fill(9, 9'h100);
      chk("fill_full", 32'(FULL), 32'd1);
      chk("fill_ovf",  32'(OVF),  32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("drain_dout", 32'(DOUT), 32'h100 + 32'(i));
         drive(1, 0, 0, '0, 1);
         cycle();
      end
      chk("drain_empty", 32'(EMPTY), 32'd1);
      chk("drain_ovf",   32'(OVF),   32'd1);

      // 4: push and pop together while full
      fill(8, 9'h010);
      drive(1, 0, 1, 9'h1FF, 1);
      cycle();
      chk("fpp_count", 32'(COUNT), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("fpp_dout", 32'(DOUT), (i == 7) ? 32'h1FF : 32'h011 + 32'(i));
         drive(1, 0, 0, '0, 1);
         cycle();
      end

      // 5: CLR then reset in mid-stream
      fill(5, 9'h020);
      drive(1, 1, 1, 9'h0EE, 0);
      cycle();
      chk("clr_count", 32'(COUNT), 32'd0);
      chk("clr_empty", 32'(EMPTY), 32'd1);
      chk("clr_ovf",   32'(OVF),   32'd0);
      fill(5, 9'h030);
      drive(0, 0, 1, 9'h0EE, 0);
      cycle();
      chk("rst2_count", 32'(COUNT), 32'd0);
      chk("rst2_empty", 32'(EMPTY), 32'd1);

`ifdef FIR_FIFO_STATS_EN
      // 6: statistics
      fill(6, 9'h040);
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, '0, 1);
         cycle();
      end
      chk("st_maxcnt", 32'(MAXCNT), 32'd6);
      fill(10, 9'h050);
      chk("st_drops", 32'(DROPS), 32'd2);
      drive(1, 1, 0, '0, 0);
      cycle();
      chk("st_maxcnt_clr", 32'(MAXCNT), 32'd0);
      chk("st_drops_clr",  32'(DROPS),  32'd0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 199) != 0),
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 9) < 6),
               WIDTH'($urandom),
               ($urandom_range(0, 9) < (((i / 300) % 2 == 0) ? 3 : 7)));
         cycle();
      end
      drive(1, 0, 0, '0, 0);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
